uart_block_sequencer: RTL
=========================

# uart_block_sequencer

Sequences the UART byte stream into fixed-size cipher blocks for the crypto core, then returns the core's result over the UART transmitter. It sits between the UART receiver's byte-ready strobe, the crypto core's block handshake and the UART transmitter's start/busy pair. It owns block framing, inter-byte timeout and error flagging, so that a single serial link drives one crypto operation at a time.

## Interface
- BLOCK_BYTES, 16, bytes per cipher block (≥2)
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a partial block
- clock_fpga  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received byte
- blk_data  out  8*BLOCK_BYTES  assembled block; first received byte in bits [8*BLOCK_BYTES-1 -: 8]
- blk_valid  out  1  block offered to crypto core
- blk_ready  in  1  crypto core accepts block
- res_data  in  8*BLOCK_BYTES  result block; same byte order as blk_data
- res_valid  in  1  result offered by crypto core
- res_ready  out  1  sequencer accepts result
- tx_data  out  8  byte for transmitter
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse: partial block discarded
- overrun_err  out  1  one-cycle pulse: byte dropped

## Operation
- States: IDLE, COLLECT, ISSUE, WAIT_RES, SEND, SEND_WAIT.
- IDLE: rx_valid stores the byte at slot 0, sets byte_cnt=1, clears the timeout counter and moves to COLLECT.
- COLLECT:
  - rx_valid stores the byte at slot byte_cnt and increments byte_cnt.
  - When the stored byte is slot BLOCK_BYTES-1, move to ISSUE and set byte_cnt=0.
  - The timeout counter increments on every cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1: pulse timeout_err, go to IDLE, byte_cnt=0. blk_data need not be cleared.
- ISSUE: blk_valid=1 and blk_data is frozen. On blk_valid&&blk_ready, move to WAIT_RES.
- WAIT_RES: res_ready=1. On res_valid&&res_ready, capture res_data into the transmit shift register, byte_cnt=0, and move to SEND.
- SEND:
  - If tx_busy=0: drive tx_data=current MSB byte, pulse tx_start, and move to SEND_WAIT.
  - Otherwise hold in SEND.
- SEND_WAIT:
  - Wait until tx_busy has been seen high and then low.
  - Then shift the register left by 8 and increment byte_cnt.
  - If byte_cnt was BLOCK_BYTES-1, go to IDLE; otherwise go to SEND.
- rx_valid in ISSUE, WAIT_RES, SEND or SEND_WAIT: the byte is dropped and overrun_err pulses. State and data are unaffected.
- byte_cnt width is clog2(BLOCK_BYTES+1). Counters never wrap; they are cleared explicitly.
- reset_n low, at any time including mid-block or mid-transmit:
  - Immediately go to IDLE.
  - All counters and the shift register are set to 0.
  - Any in-flight transmission is abandoned; no further tx_start is issued.

## Timing
- All outputs are registered. Reset values: blk_data=0, blk_valid=0, res_ready=0, tx_data=0, tx_start=0, busy=0, timeout_err=0, overrun_err=0.
- blk_valid rises on the clock edge that samples rx_valid for the final byte (visible the next cycle).
- blk_valid falls on the edge that samples blk_ready=1. res_ready rises on the same edge.
- res_ready falls on the edge that samples res_valid=1. The first tx_start follows no earlier than 1 cycle later.
- tx_start is high for exactly one cycle. tx_data is valid on that cycle and held until the next tx_start.
- Minimum spacing between tx_start pulses is 3 cycles, even if tx_busy toggles within one cycle.
- timeout_err and overrun_err are each exactly one cycle wide. Both may pulse in the same cycle only if a timeout and a drop coincide, which cannot occur by construction.
- Simultaneous rx_valid and timeout-counter terminal count: the byte wins. It is stored, the counter clears, and there is no timeout.
- Longest path: the byte-slot write decode; 100 MHz is required.

## Test plan
- Send bytes 0x00..0x0F with 1000-cycle gaps, blk_ready held 1 → blk_valid for 1 cycle with blk_data=0x000102…0E0F; busy=1 from the first byte.
- Return res_data=0xF0E1…0F with tx_busy model (busy 10 cycles after each start) → 16 tx_start pulses, tx_data sequence F0,E1,…,0F, then busy=0.
- Send 5 bytes then stall TIMEOUT_CYCLES (set to 200) → timeout_err pulse at cycle 199 after the last byte, state IDLE; the next 16 bytes form a clean block starting at slot 0.
- Hold blk_ready=0 for 50 cycles and inject rx_valid 3 times in ISSUE → 3 overrun_err pulses; blk_data unchanged; transfer completes when blk_ready=1.
- Assert reset_n=0 mid-SEND after 4 bytes → all outputs 0 within the reset; no tx_start after release; a new block is accepted normally.
- rx_valid coincident with the timeout terminal count → no timeout_err; byte stored; byte_cnt incremented.

Source files
------------

// File: rtl/uart_block_sequencer.sv
// uart_block_sequencer
// Frames the UART receive byte stream into BLOCK_BYTES-wide blocks for the
// crypto core, then streams the core's result block back out through the
// UART transmitter, most significant byte first. Only one block is in
// flight at a time; bytes arriving while a block is busy are dropped and
// flagged. A partial block that stalls too long is discarded.

module uart_block_sequencer #(
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clock_fpga,
    input  logic                     reset_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    input  logic [8*BLOCK_BYTES-1:0] res_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overrun_err
);

    localparam int BLK_W = 8 * BLOCK_BYTES;
    localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_RES,
        SEND,
        SEND_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [BLK_W-1:0] shift_reg;
    logic             seen_busy;

    logic store_byte;
    logic last_byte;
    logic tmo_fire;
    logic drop_byte;
    logic capture_res;
    logic launch_tx;
    logic advance_tx;

    // byte_cnt is the receive slot while collecting and the transmit index while sending
    assign last_byte = (byte_cnt == CNT_W'(BLOCK_BYTES - 1));

    // State register
    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the single-cycle action strobes that drive the datapath
    always_comb begin
        state_nxt   = state;
        store_byte  = 1'b0;
        tmo_fire    = 1'b0;
        drop_byte   = 1'b0;
        capture_res = 1'b0;
        launch_tx   = 1'b0;
        advance_tx  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    store_byte = 1'b1;
                    state_nxt  = COLLECT;
                end
            end
            COLLECT: begin
                // An arriving byte always beats the timeout terminal count.
                // The counter fires on the idle edge that would take it to TIMEOUT_CYCLES-1.
                if (rx_valid) begin
                    store_byte = 1'b1;
                    if (last_byte) begin
                        state_nxt = ISSUE;
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2)) begin
                    tmo_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                drop_byte = rx_valid;
                if (blk_ready) begin
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                drop_byte = rx_valid;
                if (res_valid) begin
                    capture_res = 1'b1;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                drop_byte = rx_valid;
                if (!tx_busy) begin
                    launch_tx = 1'b1;
                    state_nxt = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                // Require a full busy high->low cycle so a byte is never skipped
                drop_byte = rx_valid;
                if (seen_busy && !tx_busy) begin
                    advance_tx = 1'b1;
                    state_nxt  = last_byte ? IDLE : SEND;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte slot and inter-byte timeout counters; always cleared explicitly, never wrap
    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (store_byte) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
                tmo_cnt  <= '0;
            end else if (tmo_fire) begin
                byte_cnt <= '0;
                tmo_cnt  <= '0;
            end else if (state == COLLECT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (capture_res) begin
                byte_cnt <= '0;
            end else if (advance_tx) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
            end
        end
    end

    // Block assembly: first received byte lands in the most significant slot
    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            blk_data <= '0;
        end else if (store_byte) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (byte_cnt == CNT_W'(i)) begin
                    blk_data[8*(BLOCK_BYTES-1-i) +: 8] <= rx_data;
                end
            end
        end
    end

    // Transmit path: result shift register, held tx byte and busy-seen tracker
    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            tx_data   <= '0;
            seen_busy <= 1'b0;
        end else begin
            if (capture_res) begin
                shift_reg <= res_data;
            end else if (advance_tx) begin
                shift_reg <= shift_reg << 8;
            end
            if (launch_tx) begin
                tx_data   <= shift_reg[BLK_W-1 -: 8];
                seen_busy <= 1'b0;
            end else if (state == SEND_WAIT && tx_busy) begin
                seen_busy <= 1'b1;
            end
        end
    end

    // Registered handshake, status and pulse outputs derived from the upcoming state
    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            blk_valid   <= 1'b0;
            res_ready   <= 1'b0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            blk_valid   <= (state_nxt == ISSUE);
            res_ready   <= (state_nxt == WAIT_RES);
            tx_start    <= launch_tx;
            busy        <= (state_nxt != IDLE);
            timeout_err <= tmo_fire;
            overrun_err <= drop_byte;
        end
    end

endmodule
